// File: rtl/pong_input_pkg.sv
// Shared definitions for the serial keyboard input path: rx FSM states,
// key codes and the ASCII case-fold helper.
package pong_input_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam logic [7:0] KEY_P1_UP    = 8'h77;  // 'w'
  localparam logic [7:0] KEY_P1_DN    = 8'h73;  // 's'
  localparam logic [7:0] KEY_P2_UP    = 8'h69;  // 'i'
  localparam logic [7:0] KEY_P2_DN    = 8'h6B;  // 'k'
  localparam logic [7:0] KEY_START_SP = 8'h20;
  localparam logic [7:0] KEY_START_CR = 8'h0D;
  localparam logic [7:0] CASE_FOLD    = 8'h20;

  localparam int unsigned HOLD_W = 24;

  // Maps upper-case letters onto their lower-case code.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | CASE_FOLD;
  endfunction

endpackage

// File: rtl/uart_ctrl_rx_if.sv
// Serial line in, decoded byte/key outputs out. err_cnt exists only when
// UART_ERR_COUNT_EN is defined.
interface uart_ctrl_rx_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       start_trigger;
`ifdef UART_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  modport master (
`ifdef UART_ERR_COUNT_EN
    output err_cnt,
`endif
    input  uart_rx,
    output rx_data, rx_valid, frame_err,
    output p1_up, p1_down, p2_up, p2_down, start_trigger
  );

  modport slave (
`ifdef UART_ERR_COUNT_EN
    input  err_cnt,
`endif
    output uart_rx,
    input  rx_data, rx_valid, frame_err,
    input  p1_up, p1_down, p2_up, p2_down, start_trigger
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, registered
// byte/valid/frame-error outputs.
module uart_rx_core
  import pong_input_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_sync;
  logic             w_rx_s;
  rx_state_e        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_idx, w_idx;
  logic [7:0]       r_shift, w_shift;
  logic [7:0]       r_data, w_data;
  logic             r_valid, w_valid;
  logic             r_ferr, w_ferr;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_rx};
  end
  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_state = RX_START;
          w_cnt   = '0;
        end
      end
      // Half-bit resample rejects short glitches and centres later samples.
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = w_rx_s ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt   = '0;
          w_shift = {w_rx_s, r_shift[7:1]};
          if (r_idx == 3'd7) w_state = RX_STOP;
          else               w_idx   = r_idx + 3'd1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt = '0;
          if (w_rx_s) begin
            w_data  = r_shift;
            w_valid = 1'b1;
            w_state = RX_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = RX_BREAK;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_BREAK: begin
        if (w_rx_s) w_state = RX_IDLE;
      end
      default: w_state = RX_IDLE;
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_ctrl_rx.sv
// UART keystroke decoder: paddle hold levels with per-player timers and a
// start pulse. Define UART_ERR_COUNT_EN for a saturating frame-error count.
module uart_ctrl_rx
  import pong_input_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned HOLD_MS  = 100
) (
  input  logic           clk,
  input  logic           rst,
  uart_ctrl_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HOLD_CYCLES  = CLK_FREQ / 1000 * HOLD_MS;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  logic [7:0]        w_rx_data;
  logic              w_rx_valid;
  logic              w_frame_err;
  logic [7:0]        w_key;
  logic [1:0]        w_hit;
  logic [1:0]        w_hit_up;
  logic              w_start;
  logic [1:0]        r_up;
  logic [1:0]        r_dn;
  logic [HOLD_W-1:0] r_tmr [2];
  logic              r_start;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (bus.uart_rx),
    .o_data     (w_rx_data),
    .o_valid    (w_rx_valid),
    .o_frame_err(w_frame_err)
  );

  // Index 0 is player 1, index 1 is player 2.
  assign w_key       = fold_case(w_rx_data);
  assign w_hit[0]    = w_rx_valid && (w_key == KEY_P1_UP || w_key == KEY_P1_DN);
  assign w_hit_up[0] = (w_key == KEY_P1_UP);
  assign w_hit[1]    = w_rx_valid && (w_key == KEY_P2_UP || w_key == KEY_P2_DN);
  assign w_hit_up[1] = (w_key == KEY_P2_UP);
  assign w_start     = w_rx_valid &&
                       (w_rx_data == KEY_START_SP || w_rx_data == KEY_START_CR);

  // A reload takes priority over the timer expiring in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up    <= '0;
      r_dn    <= '0;
      r_start <= 1'b0;
      for (int p = 0; p < 2; p++) r_tmr[p] <= '0;
    end else begin
      r_start <= w_start;
      for (int p = 0; p < 2; p++) begin
        if (w_hit[p]) begin
          r_tmr[p] <= HOLD_LOAD;
          r_up[p]  <= w_hit_up[p];
          r_dn[p]  <= !w_hit_up[p];
        end else if (r_tmr[p] != '0) begin
          r_tmr[p] <= r_tmr[p] - 1'b1;
          if (r_tmr[p] == HOLD_W'(1)) begin
            r_up[p] <= 1'b0;
            r_dn[p] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef UART_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_err_cnt <= '0;
    else if (w_frame_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.rx_data       = w_rx_data;
  assign bus.rx_valid      = w_rx_valid;
  assign bus.frame_err     = w_frame_err;
  assign bus.p1_up         = r_up[0];
  assign bus.p1_down       = r_dn[0];
  assign bus.p2_up         = r_up[1];
  assign bus.p2_down       = r_dn[1];
  assign bus.start_trigger = r_start;

endmodule

// File: doc/uart_ctrl_rx.md
Name: uart_ctrl_rx

Overview:
- UART 8N1 receiver and key decoder that turns serial keystrokes into paddle hold levels and a start pulse.
- Sits in the input path between the board uart_rx pin and the game/menu consumers of p1_up/p1_down/p2_up/p2_down/start_trigger.
- Runs on the 50 MHz system clock, not the pixel clock.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- HOLD_MS, 100: how long a direction stays asserted after its last matching byte. HOLD_CYCLES = CLK_FREQ/1000*HOLD_MS.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- uart_rx, input, 1: raw serial line, idle high, asynchronous to clk.
- rx_data, output, 8: last good byte received.
- rx_valid, output, 1: one-cycle pulse when rx_data updates.
- frame_err, output, 1: one-cycle pulse when a stop bit samples low.
- p1_up, output, 1: player 1 up, level.
- p1_down, output, 1: player 1 down, level.
- p2_up, output, 1: player 2 up, level.
- p2_down, output, 1: player 2 down, level.
- start_trigger, output, 1: one-cycle pulse for start/select.

Behaviour:
- Synchroniser: uart_rx passes through a 2-FF synchroniser (rx_s); both flops reset to 1.
- Reset values: all outputs 0, rx_data 8'h00, FSM IDLE, all counters 0.
- Reset mid-frame discards the partial byte and clears all hold levels.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1, resample. rx_s==0 -> DATA (count cleared, bit index 0). rx_s==1 -> IDLE (glitch rejected, nothing reported).
  - DATA: sample every CLKS_PER_BIT clocks, LSB first, into a shift register. After the 8th bit -> STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx_s==1: rx_data<=byte, rx_valid pulse next cycle, -> IDLE.
    - rx_s==0: frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE.
- Decode: registered, in the cycle after rx_valid, so outputs change 1 clk after the rx_valid pulse. Case-insensitive.
  - 'w'/'W' (0x77/0x57): p1_up=1, p1_down=0, P1 timer reloads to HOLD_CYCLES.
  - 's'/'S': p1_down=1, p1_up=0, P1 timer reloads.
  - 'i'/'I': p2_up, same rules with the P2 timer.
  - 'k'/'K': p2_down, same rules with the P2 timer.
  - 0x20 (space) or 0x0D (CR): start_trigger pulse for exactly 1 clk.
  - Any other byte: no effect; rx_valid still pulses.
- Each player's up/down pair is mutually exclusive; the latest byte wins.
- Hold timers: one 24-bit down-counter per player. Decrements while nonzero. On transition to 0, that player's up and down clear on the same cycle.
- If a reload and a timer reaching 0 coincide, the reload wins.
- Repeated same key (terminal auto-repeat) keeps the level high with no gap.
- Back-to-back bytes with no idle gap are received correctly: IDLE->START detection takes effect on the cycle after STOP completes.

Optional Feature:
- Macro: UART_ERR_COUNT_EN.
- Defined: adds output err_cnt [7:0], an 8-bit saturating count of frame_err pulses. Resets to 0 and holds at 255.
- Undefined: port absent and no counter logic. frame_err pulse behaviour is identical either way.

Decomposition:
- Shared package pong_input_pkg:
  - rx FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - Key code constants: KEY_P1_UP, KEY_P1_DN, KEY_P2_UP, KEY_P2_DN, KEY_START_SP, KEY_START_CR.
  - Case-fold mask 8'h20.
- One sub-module, uart_rx_core: synchroniser plus FSM, producing rx_data/rx_valid/frame_err.
- Key decode and hold timers stay in uart_ctrl_rx.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (10 clk/bit), HOLD_MS=1 (1000 cycles).
- Send 0x57 'W': rx_valid pulses once with rx_data=0x57. p1_up rises 1 clk later and falls exactly 1000 clks after that; p1_down stays 0.
- Send 's' then 'w' back-to-back: p1_down high until 'w' decodes, then p1_down=0 and p1_up=1 in the same cycle, with no overlap.
- Send 0x20, then 0x0D: two start_trigger pulses, each 1 clk wide; paddle outputs unchanged.
- Drive a 3-clk low glitch on uart_rx: no rx_valid and no frame_err; FSM back in IDLE.
- Send 'k' with the stop bit forced low for 30 clks: frame_err pulses once, no rx_valid, p2_down stays 0. A following 'i' is then received normally. With UART_ERR_COUNT_EN, err_cnt==1.
- Assert rst during bit 4 of 'w' while p2_up is held: all outputs go 0 immediately. After release, a clean 'w' decodes correctly.
